// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

  // Frame sequencing states of the transmitter.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // One start bit, eight data bits, one stop bit.
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_mhz,
                                           input int unsigned baud);
    return (clk_mhz * 32'd1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 frame serialiser: divisor counter, bit index and shift register.
// Loads a byte on start (only honoured in IDLE) and drives a registered tx.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // The last cycle of the stop bit; the scheduler frees the line on this edge.
  assign done = (state == STOP) && bit_end;

  // Frame sequencer; tx is registered so it changes one edge after each decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (start) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'(DATA_BITS - 1)) begin
              idx   <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // Present the next bit now so it is on the line for a full DIV.
              idx   <= idx + 1'b1;
              shreg <= {1'b0, shreg[7:1]};
              tx    <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          idx   <= '0;
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler sharing one 8N1 UART TX line.
// Arbitration and handshake live here; framing is done by uart_tx_shifter.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned CLK_MHZ = 50,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned DIV     = calc_div(CLK_MHZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  logic       busy_q;
  logic       grant_q;
  logic       last_q;
  logic       sel;
  logic       take;
  logic [7:0] sel_data;
  logic       sh_done;

  // Round-robin choice: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    sel        = req1_valid && (!req0_valid || !last_q);
    req0_ready = !busy_q && req0_valid && !sel;
    req1_ready = !busy_q && req1_valid &&  sel;
    take       = req0_ready || req1_ready;
    sel_data   = sel ? req1_data : req0_data;
  end

  // Handshake bookkeeping; busy tracks the shifter leaving and re-entering IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (take) begin
      busy_q  <= 1'b1;
      grant_q <= sel;
      last_q  <= sel;
    end else if (sh_done) begin
      busy_q  <= 1'b0;
    end
  end

  uart_tx_shifter #(
    .DIV (DIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (take),
    .data  (sel_data),
    .tx    (tx),
    .done  (sh_done)
  );

  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
